// File: rtl/snes_reset_sequencer.sv
// SNES console reset sequencer: debounced reset, APU sync alignment,
// phase-aligned CPU divider start and delayed CPU reset release.
module snes_reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_TIMEOUT    = 1 << 24,
  parameter int RELEASE_DELAY   = 64
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       console_reset_n,
  input  logic       apu_sync_n,
  input  logic       apu_phase0,
  output logic       apu_div7,
  output logic       cpu_div_run,
  output logic       apu_reset_n,
  output logic       cpu_reset_n,
  output logic [2:0] state,
  output logic       sync_error
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TOW = $clog2(SYNC_TIMEOUT) + 1;
  localparam int RLW = $clog2(RELEASE_DELAY) + 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(SYNC_TIMEOUT - 1);
  localparam logic [RLW-1:0] RL_LAST = RLW'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FREE    = 3'd1,
    S_HOLD    = 3'd2,
    S_SYNCING = 3'd3,
    S_ALIGN   = 3'd4,
    S_RELEASE = 3'd5,
    S_RUNNING = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

  state_t           st_q;
  state_t           st_d;
  logic [1:0]       cr_sync;
  logic [2:0]       as_sync;
  logic             rst_db;
  logic [DBW-1:0]   db_cnt;
  logic [TOW-1:0]   to_cnt;
  logic [TOW-1:0]   to_d;
  logic [RLW-1:0]   rl_cnt;
  logic [RLW-1:0]   rl_d;
  logic             div7_d;
  logic             run_d;
  logic             arst_d;
  logic             crst_d;
  logic             err_d;
  logic             sync_fall;

  assign state     = st_q;
  assign sync_fall = as_sync[2] & ~as_sync[1];

  always_ff @(posedge clkin) begin
    if (reset) begin
      cr_sync <= 2'b11;
      as_sync <= 3'b111;
      rst_db  <= 1'b1;
      db_cnt  <= '0;
    end else begin
      cr_sync <= {cr_sync[0], console_reset_n};
      as_sync <= {as_sync[1:0], apu_sync_n};
      if (cr_sync[1] == rst_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        rst_db <= cr_sync[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    div7_d = apu_div7;
    run_d  = cpu_div_run;
    arst_d = apu_reset_n;
    crst_d = cpu_reset_n;
    err_d  = sync_error;
    to_d   = to_cnt;
    rl_d   = rl_cnt;
    unique case (st_q)
      S_INIT: begin
        st_d   = S_FREE;
        div7_d = 1'b1;
        run_d  = 1'b1;
        arst_d = 1'b1;
        crst_d = 1'b1;
      end
      S_HOLD: begin
        if (rst_db) begin
          st_d   = S_SYNCING;
          arst_d = 1'b1;
          to_d   = '0;
        end
      end
      S_SYNCING: begin
        if (sync_fall) begin
          st_d   = S_ALIGN;
          div7_d = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          st_d   = S_FAULT;
          err_d  = 1'b1;
          div7_d = 1'b1;
          run_d  = 1'b1;
          crst_d = 1'b1;
        end else if (to_cnt != '1) begin
          to_d = to_cnt + TOW'(1);
        end
      end
      S_ALIGN: begin
        if (apu_phase0) begin
          st_d  = S_RELEASE;
          run_d = 1'b1;
          rl_d  = RL_LAST;
        end
      end
      S_RELEASE: begin
        if (rl_cnt == '0) begin
          st_d   = S_RUNNING;
          crst_d = 1'b1;
        end else begin
          rl_d = rl_cnt - RLW'(1);
        end
      end
      S_FREE, S_RUNNING, S_FAULT: begin
      end
      default: begin
      end
    endcase
    // Console reset request outranks every same-cycle event
    if (!rst_db && st_q != S_INIT && st_q != S_HOLD) begin
      st_d   = S_HOLD;
      div7_d = 1'b0;
      run_d  = 1'b0;
      arst_d = 1'b0;
      crst_d = 1'b0;
      to_d   = '0;
      rl_d   = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      st_q        <= S_INIT;
      apu_div7    <= 1'b0;
      cpu_div_run <= 1'b0;
      apu_reset_n <= 1'b0;
      cpu_reset_n <= 1'b0;
      sync_error  <= 1'b0;
      to_cnt      <= '0;
      rl_cnt      <= '0;
    end else begin
      st_q        <= st_d;
      apu_div7    <= div7_d;
      cpu_div_run <= run_d;
      apu_reset_n <= arst_d;
      cpu_reset_n <= crst_d;
      sync_error  <= err_d;
      to_cnt      <= to_d;
      rl_cnt      <= rl_d;
    end
  end

endmodule

// File: tb/tb_snes_reset_sequencer.sv
// Bench for snes_reset_sequencer: directed scenarios, cycle-accurate
// timestamp model compared every cycle plus literal spot checks.
module tb_snes_reset_sequencer;

  localparam int DB = 4;
  localparam int TO = 64;
  localparam int RD = 8;

  logic       clkin;
  logic       reset;
  logic       console_reset_n;
  logic       apu_sync_n;
  logic       apu_phase0;
  logic       apu_div7;
  logic       cpu_div_run;
  logic       apu_reset_n;
  logic       cpu_reset_n;
  logic [2:0] state;
  logic       sync_error;

  int n_tests = 0;
  int n_fail  = 0;

  snes_reset_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .SYNC_TIMEOUT(TO),
    .RELEASE_DELAY(RD)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .console_reset_n(console_reset_n),
    .apu_sync_n(apu_sync_n),
    .apu_phase0(apu_phase0),
    .apu_div7(apu_div7),
    .cpu_div_run(cpu_div_run),
    .apu_reset_n(apu_reset_n),
    .cpu_reset_n(cpu_reset_n),
    .state(state),
    .sync_error(sync_error)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  logic [3:0] drives;
  assign drives = {apu_div7, cpu_div_run, apu_reset_n, cpu_reset_n};

  // Model: input histories plus entry timestamps
  int         cyc = 0;
  logic [2:0] m_st = 3'd0;
  logic       m_err = 1'b0;
  logic       m_db = 1'b1;
  int         t_sync = 0;
  int         t_rel = 0;
  logic [3:0] cr_h = '1;
  logic [3:0] as_h = '1;
  logic [DB-2:0] syn_h = '1;

  logic          syn;
  logic [DB-1:0] syn_win;
  logic          fall;
  logic [2:0]    n_st;
  logic          n_err;
  logic          n_db;
  int            n_ts;
  int            n_tr;

  always_comb begin
    syn     = cr_h[1];
    syn_win = {syn_h, syn};
    fall    = as_h[2] & ~as_h[1];
    n_db    = (syn_win == {DB{~m_db}}) ? syn : m_db;
    n_st    = m_st;
    n_err   = m_err;
    n_ts    = t_sync;
    n_tr    = t_rel;
    if (m_st == 3'd0) begin
      n_st = 3'd1;
    end else if (m_st == 3'd2) begin
      if (m_db) begin
        n_st = 3'd3;
        n_ts = cyc;
      end
    end else if (!m_db) begin
      n_st = 3'd2;
    end else if (m_st == 3'd3) begin
      if (fall) n_st = 3'd4;
      else if (cyc - t_sync == TO) begin
        n_st  = 3'd7;
        n_err = 1'b1;
      end
    end else if (m_st == 3'd4 && apu_phase0) begin
      n_st = 3'd5;
      n_tr = cyc;
    end else if (m_st == 3'd5 && cyc - t_rel == RD) begin
      n_st = 3'd6;
    end
  end

  always @(posedge clkin) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_st  <= 3'd0;
      m_err <= 1'b0;
      m_db  <= 1'b1;
      cr_h  <= '1;
      as_h  <= '1;
      syn_h <= '1;
    end else begin
      m_st   <= n_st;
      m_err  <= n_err;
      m_db   <= n_db;
      t_sync <= n_ts;
      t_rel  <= n_tr;
      cr_h   <= {cr_h[2:0], console_reset_n};
      as_h   <= {as_h[2:0], apu_sync_n};
      syn_h  <= syn_win[DB-2:0];
    end
  end

  // Drives {div7, run, apu_rst_n, cpu_rst_n} follow from the state alone
  function automatic logic [3:0] outs_of(input logic [2:0] s);
    case (s)
      3'd1: return 4'b1111;
      3'd3: return 4'b0010;
      3'd4: return 4'b1010;
      3'd5: return 4'b1110;
      3'd6: return 4'b1111;
      3'd7: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clkin);
      check("model", {24'd0, state, drives, sync_error},
            {24'd0, m_st, outs_of(m_st), m_err});
    end
  endtask

  task automatic pulse_phase0();
    apu_phase0 = 1'b1;
    tick(1);
    apu_phase0 = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    console_reset_n = 1'b1;
    apu_sync_n      = 1'b1;
    apu_phase0      = 1'b0;

    // Power-up
    tick(3);
    check("reset_state", state, 0);
    check("reset_drives", drives, 4'b0000);
    check("reset_err", sync_error, 0);
    reset = 1'b0;
    tick(1);
    check("init_state", state, 1);
    check("init_drives", drives, 4'b1111);

    // Debounce: short glitch rejected
    console_reset_n = 1'b0;
    tick(3);
    console_reset_n = 1'b1;
    tick(10);
    check("glitch_state", state, 1);

    // Debounce: long low accepted after 2+4+1 edges
    console_reset_n = 1'b0;
    tick(6);
    check("db_pre_state", state, 1);
    tick(1);
    check("hold_state", state, 2);
    check("hold_drives", drives, 4'b0000);
    tick(3);

    // Nominal sync
    console_reset_n = 1'b1;
    tick(6);
    check("hold_keep", state, 2);
    tick(1);
    check("sync_state", state, 3);
    check("sync_apu_rst", apu_reset_n, 1);
    apu_sync_n = 1'b0;
    tick(2);
    check("sync_wait", state, 3);
    tick(1);
    check("align_state", state, 4);
    check("align_div7", apu_div7, 1);
    pulse_phase0();
    check("rel_state", state, 5);
    check("rel_run", cpu_div_run, 1);
    tick(7);
    check("rel_cpu_held", cpu_reset_n, 0);
    tick(1);
    check("run_cpu_rst", cpu_reset_n, 1);
    check("run_state", state, 6);

    // Pre-low sync pin does not count as an edge
    console_reset_n = 1'b0;
    tick(7);
    check("pre_hold", state, 2);
    console_reset_n = 1'b1;
    tick(7);
    tick(5);
    check("prelow_stay", state, 3);
    apu_sync_n = 1'b1;
    tick(3);
    apu_sync_n = 1'b0;
    tick(3);
    check("prelow_align", state, 4);

    // Timeout into FAULT
    apu_sync_n = 1'b1;
    console_reset_n = 1'b0;
    tick(7);
    check("to_hold", state, 2);
    console_reset_n = 1'b1;
    tick(7);
    check("to_sync", state, 3);
    tick(63);
    check("to_last_sync", state, 3);
    tick(1);
    check("fault_state", state, 7);
    check("fault_err", sync_error, 1);
    check("fault_cpu_rst", cpu_reset_n, 1);

    // Recovery keeps sync_error sticky
    console_reset_n = 1'b0;
    tick(7);
    check("rec_hold", state, 2);
    console_reset_n = 1'b1;
    tick(7);
    apu_sync_n = 1'b0;
    tick(3);
    check("rec_align", state, 4);
    pulse_phase0();
    tick(8);
    check("rec_running", state, 6);
    check("rec_err", sync_error, 1);

    // Reset request beats same-cycle phase0
    apu_sync_n = 1'b1;
    console_reset_n = 1'b0;
    tick(7);
    console_reset_n = 1'b1;
    tick(7);
    apu_sync_n = 1'b0;
    tick(3);
    check("race_align", state, 4);
    console_reset_n = 1'b0;
    tick(6);
    pulse_phase0();
    check("race_state", state, 2);
    check("race_run", cpu_div_run, 0);

    // Block reset from RUNNING
    console_reset_n = 1'b1;
    tick(7);
    apu_sync_n = 1'b1;
    tick(3);
    apu_sync_n = 1'b0;
    tick(3);
    pulse_phase0();
    tick(8);
    check("blk_running", state, 6);
    reset = 1'b1;
    tick(1);
    check("blk_state", state, 0);
    check("blk_drives", drives, 4'b0000);
    check("blk_err", sync_error, 0);
    reset = 1'b0;
    tick(2);
    check("blk_free", state, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
